// File: rtl/axi4_sram_slave.sv
// AXI4-Lite-subset responder backed by a single-port word RAM, one transaction at a time.
// Optional macro RAM_SLVERR_EN adds bresp/rresp ports and SLVERR for out-of-range addresses.
module axi4_sram_slave #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic        s_axi_rvalid,
`ifdef RAM_SLVERR_EN
    output logic [1:0]  s_axi_bresp,
    output logic [1:0]  s_axi_rresp,
`endif
    input  logic        s_axi_rready
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_WACC, S_WLAT, S_BRESP, S_RACC, S_RLAT, S_RRESP
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        mem [MEM_DEPTH];
    logic [IDX_W-1:0]   widx, ridx;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [CNT_W-1:0]   cnt;
    logic               aw_got, w_got, prefer_wr;
    logic               aw_hs_c, w_hs_c, wreq_c, wr_en_c, unused_addr_bits_c;

    assign aw_hs_c = s_axi_awvalid && s_axi_awready;
    assign w_hs_c  = s_axi_wvalid && s_axi_wready;
    assign wreq_c  = s_axi_awvalid || s_axi_wvalid;
    assign unused_addr_bits_c = ^{s_axi_awaddr, s_axi_araddr};

`ifdef RAM_SLVERR_EN
    logic w_oor, r_oor;
    assign wr_en_c = !rst && (state == S_WLAT) && (cnt == '0) && !w_oor;
`else
    assign wr_en_c = !rst && (state == S_WLAT) && (cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Write wins an IDLE tie only when prefer_wr is set, giving alternating fairness.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (wreq_c && (!s_axi_arvalid || prefer_wr)) state_nxt = S_WACC;
                     else if (s_axi_arvalid)                      state_nxt = S_RACC;
            S_WACC:  if ((aw_got || aw_hs_c) && (w_got || w_hs_c)) state_nxt = S_WLAT;
            S_WLAT:  if (cnt == '0) state_nxt = S_BRESP;
            S_BRESP: if (s_axi_bready) state_nxt = S_IDLE;
            S_RACC:  state_nxt = S_RLAT;
            S_RLAT:  if (cnt == '0) state_nxt = S_RRESP;
            S_RRESP: if (s_axi_rready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (state)
            S_WACC: begin
                s_axi_awready = !aw_got;
                s_axi_wready  = !w_got;
            end
            S_BRESP: s_axi_bvalid  = 1'b1;
            S_RACC:  s_axi_arready = 1'b1;
            S_RRESP: s_axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            prefer_wr   <= 1'b1;
            widx        <= '0;
            ridx        <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_rdata <= '0;
`ifdef RAM_SLVERR_EN
            w_oor       <= 1'b0;
            r_oor       <= 1'b0;
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                end
                S_WACC: begin
                    cnt <= CNT_W'(LATENCY);
                    if (aw_hs_c) begin
                        aw_got <= 1'b1;
                        widx   <= s_axi_awaddr[IDX_W+1:2];
`ifdef RAM_SLVERR_EN
                        w_oor  <= |s_axi_awaddr[31:IDX_W+2];
`endif
                    end
                    if (w_hs_c) begin
                        w_got   <= 1'b1;
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                    end
                end
                S_WLAT: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
`ifdef RAM_SLVERR_EN
                    else           s_axi_bresp <= w_oor ? 2'b10 : 2'b00;
`endif
                end
                S_BRESP: if (s_axi_bready) prefer_wr <= 1'b0;
                S_RACC: begin
                    cnt  <= CNT_W'(LATENCY);
                    ridx <= s_axi_araddr[IDX_W+1:2];
`ifdef RAM_SLVERR_EN
                    r_oor <= |s_axi_araddr[31:IDX_W+2];
`endif
                end
                S_RLAT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
`ifdef RAM_SLVERR_EN
                        s_axi_rdata <= r_oor ? 32'h0 : mem[ridx];
                        s_axi_rresp <= r_oor ? 2'b10 : 2'b00;
`else
                        s_axi_rdata <= mem[ridx];
`endif
                    end
                end
                S_RRESP: if (s_axi_rready) prefer_wr <= 1'b1;
                default: ;
            endcase
        end
    end

    // RAM write port with per-byte enables.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: stimulus pushes expected B/R beats, a negedge monitor checks them.
module tb_axi4_sram_slave;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] rdata;
`ifdef RAM_SLVERR_EN
    logic [1:0]  bresp, rresp;
`endif

    axi4_sram_slave #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rvalid(rvalid),
`ifdef RAM_SLVERR_EN
        .s_axi_bresp(bresp), .s_axi_rresp(rresp),
`endif
        .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    rexp_t       exp_r[$];
    logic [1:0]  exp_b[$];
    rexp_t       r_e;
    logic [1:0]  b_e;
    int checks = 0, errors = 0, cyc = 0, b_hs_cyc = 0, r_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a valid&&ready seen at negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                b_hs_cyc = cyc;
                chk("b_beat_expected", 32'(exp_b.size() > 0), 32'd1);
                if (exp_b.size() > 0) begin
                    b_e = exp_b.pop_front();
`ifdef RAM_SLVERR_EN
                    chk("bresp", 32'(bresp), 32'(b_e));
`endif
                end
            end
            if (rvalid && rready) begin
                r_hs_cyc = cyc;
                chk("r_beat_expected", 32'(exp_r.size() > 0), 32'd1);
                if (exp_r.size() > 0) begin
                    r_e = exp_r.pop_front();
                    chk("rdata", rdata, r_e.data);
`ifdef RAM_SLVERR_EN
                    chk("rresp", 32'(rresp), 32'(r_e.resp));
`endif
                end
            end
        end
    end

    function automatic logic [1:0] resp_for(input logic [31:0] addr);
`ifdef RAM_SLVERR_EN
        return (addr >= 32'(DEPTH * 4)) ? 2'b10 : 2'b00;
`else
        return (addr == 32'hFFFF_FFFF) ? 2'b11 : 2'b00;
`endif
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input bit exp_beat);
        int lead = w_lead;
        int t = 0;
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        if (exp_beat) exp_b.push_back(resp_for(addr));
        @(posedge clk); #1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        if (lead == 0) begin awaddr = addr; awvalid = 1'b1; end
        while (!(aw_done && w_done) && t < 100) begin
            @(negedge clk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk); #1;
            t++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && !awvalid) begin
                lead--;
                if (lead <= 0) begin awaddr = addr; awvalid = 1'b1; end
            end
        end
        chk("write_accepted", 32'(aw_done && w_done), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data);
        rexp_t e;
        int t = 0;
        bit done = 0, fire;
        e.data = exp_data;
        e.resp = resp_for(addr);
        exp_r.push_back(e);
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        while (!done && t < 100) begin
            @(negedge clk);
            fire = arvalid && arready;
            @(posedge clk); #1;
            t++;
            if (fire) begin arvalid = 1'b0; done = 1; end
        end
        chk("read_accepted", 32'(done), 32'd1);
    endtask

    // Counts rising edges until the selected valid is seen (bounded).
    task automatic edges_to_valid(input bit is_b, output int k);
        k = 0;
        while (!(is_b ? bvalid : rvalid) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_b.size() + exp_r.size()) != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("queues_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
    endtask

    task automatic chk_quiet(input string name);
        chk(name, 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    int k;

    initial begin
        // Power-on reset: everything quiet, rdata cleared.
        repeat (3) begin @(posedge clk); #1; end
        chk_quiet("reset_handshakes");
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_quiet("idle_after_reset");

        // Full-word write, bvalid LATENCY+1 edges after the AW/W handshake, then readback.
        axi_write(32'h100, 32'hDEADBEEF, 4'hF, 0, 1);
        edges_to_valid(1, k);
        chk("b_latency", 32'(k), 32'(LAT + 1));
        axi_read(32'h100, 32'hDEADBEEF);
        edges_to_valid(0, k);
        chk("r_latency", 32'(k), 32'(LAT + 1));
        drain();

        // Byte strobes 0101 merge into the existing word.
        axi_write(32'h100, 32'h11223344, 4'b0101, 0, 1);
        axi_read(32'h100, 32'hDE22BE44);
        drain();

        // W leads AW by three cycles: one write, one B beat.
        axi_write(32'h300, 32'hA5A50001, 4'hF, 3, 1);
        axi_read(32'h300, 32'hA5A50001);
        drain();

        // Reset held 3 cycles during WLAT abandons the write.
        axi_write(32'h200, 32'hCAFEF00D, 4'hF, 0, 1);
        drain();
        axi_write(32'h200, 32'h12345678, 4'hF, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_quiet("midwrite_reset_quiet");
        chk("midwrite_reset_rdata", rdata, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        chk_quiet("post_reset_quiet");
        axi_read(32'h200, 32'hCAFEF00D);
        drain();

        // Simultaneous AW+W+AR from reset: write first, then read.
        pulse_reset(1);
        fork
            axi_write(32'h400, 32'h55AA55AA, 4'hF, 0, 1);
            axi_read(32'h100, 32'hDE22BE44);
        join
        drain();
        chk("tie_write_first", 32'(b_hs_cyc < r_hs_cyc), 32'd1);
        // After a lone write prefer_wr is clear, so the next tie goes to the read (old data).
        axi_write(32'h404, 32'h0BADF00D, 4'hF, 0, 1);
        drain();
        fork
            axi_write(32'h100, 32'h77777777, 4'hF, 0, 1);
            axi_read(32'h100, 32'hDE22BE44);
        join
        drain();
        chk("tie_read_first", 32'(r_hs_cyc < b_hs_cyc), 32'd1);
        axi_read(32'h100, 32'h77777777);
        axi_read(32'h404, 32'h0BADF00D);
        drain();

        // rready held low: rvalid/rdata stable, no further AR accepted.
        rready = 1'b0;
        axi_read(32'h300, 32'hA5A50001);
        edges_to_valid(0, k);
        chk("bp_rvalid_seen", 32'(rvalid), 32'd1);
        araddr = 32'h400; arvalid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_rvalid_held", 32'(rvalid), 32'd1);
            chk("bp_rdata_held", rdata, 32'hA5A50001);
            chk("bp_no_arready", 32'(arready), 32'd0);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        drain();

`ifdef RAM_SLVERR_EN
        // Out-of-range: write suppressed with SLVERR, read returns zero with SLVERR.
        axi_write(32'h1100, 32'h13579BDF, 4'hF, 0, 1);
        axi_read(32'h100, 32'h77777777);
        axi_read(32'h1000, 32'h0);
        drain();
`else
        // Upper address bits ignored: 0x1100 aliases 0x100.
        axi_write(32'h1100, 32'h13579BDF, 4'hF, 0, 1);
        axi_read(32'h100, 32'h13579BDF);
        axi_read(32'h1404, 32'h0BADF00D);
        drain();
`endif

        repeat (3) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
